// File: rtl/gf180mcu_fd_sc_mcu7t5v0__arb3rr_1.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__arb3rr_1.sv - three-way round-robin arbiter with grant locking and hold-timeout preemption
module gf180mcu_fd_sc_mcu7t5v0__arb3rr_1 #(
  parameter int HOLD_MAX = 16
) (
  input  logic CLK,
  input  logic RN,
  input  logic A1,
  input  logic A2,
  input  logic A3,
  output logic G1,
  output logic G2,
  output logic G3,
  output logic Z,
  output logic BUSY,
  output logic PRE,
  inout  wire  VDD,
  inout  wire  VSS
);

  localparam int CNT_W_RAW = $clog2(HOLD_MAX + 1);
  localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_e;

  state_e           state_q;
  logic [2:0]       g_q;        // one-hot grant, bit 0 = requester 1
  logic             busy_q;
  logic             pre_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [1:0]       last_q;     // index 1..3 of the most recent owner

  logic [2:0] req;
  logic [2:0] win_oh;
  logic [1:0] owner_idx;
  logic       owner_req;
  logic       other_req;

  // Power pins carry no logic; tie them off so they are consumed.
  logic unused_pwr;
  assign unused_pwr = VDD ^ VSS;

  assign req = {A3, A2, A1};
  assign Z   = |req;

  assign G1   = g_q[0];
  assign G2   = g_q[1];
  assign G3   = g_q[2];
  assign BUSY = busy_q;
  assign PRE  = pre_q;

  // Round-robin pick: search starts just after the last owner and wraps 3 -> 1.
  always_comb begin
    win_oh = 3'b000;
    case (last_q)
      2'd1: begin
        if      (req[1]) win_oh = 3'b010;
        else if (req[2]) win_oh = 3'b100;
        else if (req[0]) win_oh = 3'b001;
      end
      2'd2: begin
        if      (req[2]) win_oh = 3'b100;
        else if (req[0]) win_oh = 3'b001;
        else if (req[1]) win_oh = 3'b010;
      end
      default: begin
        if      (req[0]) win_oh = 3'b001;
        else if (req[1]) win_oh = 3'b010;
        else if (req[2]) win_oh = 3'b100;
      end
    endcase
  end

  // Owner bookkeeping and saturating hold counter.
  always_comb begin
    owner_idx = 2'd3;
    if (g_q[0])      owner_idx = 2'd1;
    else if (g_q[1]) owner_idx = 2'd2;
    owner_req = |(req & g_q);
    other_req = |(req & ~g_q);
    cnt_d     = cnt_q;
    if (HOLD_MAX > 0 && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
  end

  // Arbitration FSM; every output is registered here so grants never glitch.
  always_ff @(posedge CLK) begin
    if (!RN) begin
      state_q <= S_IDLE;
      g_q     <= 3'b000;
      busy_q  <= 1'b0;
      pre_q   <= 1'b0;
      cnt_q   <= '0;
      last_q  <= 2'd3;
    end else begin
      case (state_q)
        S_IDLE: begin
          pre_q <= 1'b0;
          if (|req) begin
            g_q     <= win_oh;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (!owner_req) begin
            g_q     <= 3'b000;
            last_q  <= owner_idx;
            pre_q   <= 1'b0;
            state_q <= S_RELEASE;
          end else if (HOLD_MAX > 0 && cnt_q == CNT_MAX && other_req) begin
            g_q     <= 3'b000;
            last_q  <= owner_idx;
            pre_q   <= 1'b1;
            state_q <= S_RELEASE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_RELEASE: begin
          // The dead cycle: last_q already points at the owner just released.
          pre_q <= 1'b0;
          if (|req) begin
            g_q     <= win_oh;
            cnt_q   <= '0;
            state_q <= S_GRANT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          g_q     <= 3'b000;
          busy_q  <= 1'b0;
          pre_q   <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__arb3rr_1.sv
// tb/tb_gf180mcu_fd_sc_mcu7t5v0__arb3rr_1.sv - directed self-checking bench for the round-robin arbiter
module tb_gf180mcu_fd_sc_mcu7t5v0__arb3rr_1;

  logic clk;
  logic [3:0]      rn;
  logic [3:0][2:0] a;
  wire  [3:0][2:0] g;
  wire  [3:0]      z;
  wire  [3:0]      busy;
  wire  [3:0]      pre;
  wire vdd = 1'b1;
  wire vss = 1'b0;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: HOLD_MAX=16, 1: HOLD_MAX=4, 2: HOLD_MAX=1, 3: HOLD_MAX=0
  for (genvar i = 0; i < 4; i++) begin : g_dut
    localparam int HM = (i == 0) ? 16 : (i == 1) ? 4 : (i == 2) ? 1 : 0;
    gf180mcu_fd_sc_mcu7t5v0__arb3rr_1 #(.HOLD_MAX(HM)) u_dut (
      .CLK (clk),
      .RN  (rn[i]),
      .A1  (a[i][0]),
      .A2  (a[i][1]),
      .A3  (a[i][2]),
      .G1  (g[i][0]),
      .G2  (g[i][1]),
      .G3  (g[i][2]),
      .Z   (z[i]),
      .BUSY(busy[i]),
      .PRE (pre[i]),
      .VDD (vdd),
      .VSS (vss)
    );
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    int ord[4];
    logic [2:0] exp_g;
    ord = '{1, 2, 3, 1};
    rn = 4'b0000;
    a  = '0;

    // Reset with all requests high
    a[0] = 3'b111;
    step(); step();
    chk("rst_g", g[0], 3'b000);
    chk("rst_busy", {2'b0, busy[0]}, 3'b000);
    chk("rst_pre", {2'b0, pre[0]}, 3'b000);
    chk("rst_z", {2'b0, z[0]}, 3'b001);
    rn[0] = 1'b1;
    step();
    chk("rst_first_g1", g[0], 3'b001);

    // Round robin 1,2,3,1 with a dead cycle between owners
    for (int i = 0; i < 3; i++) begin
      exp_g = 3'b001 << (ord[i] - 1);
      step(); chk("rr_hold", g[0], exp_g);
      step(); chk("rr_hold", g[0], exp_g);
      a[0][ord[i] - 1] = 1'b0;
      step();
      chk("rr_gap_g", g[0], 3'b000);
      chk("rr_gap_busy", {2'b0, busy[0]}, 3'b001);
      a[0][ord[i] - 1] = 1'b1;
      step();
      exp_g = 3'b001 << (ord[i + 1] - 1);
      chk("rr_next", g[0], exp_g);
    end
    a[0] = 3'b000;
    step();
    chk("rr_rel_g", g[0], 3'b000);
    chk("rr_rel_busy", {2'b0, busy[0]}, 3'b001);
    step();
    chk("rr_idle_busy", {2'b0, busy[0]}, 3'b000);

    // Single requester A2: 4 cycles, release, re-wins as sole requester
    a[0] = 3'b010;
    for (int i = 0; i < 4; i++) begin
      step(); chk("single_g2", g[0], 3'b010);
    end
    a[0] = 3'b000;
    step();
    chk("single_rel_g", g[0], 3'b000);
    chk("single_rel_busy", {2'b0, busy[0]}, 3'b001);
    a[0] = 3'b010;
    step();
    chk("single_rewin", g[0], 3'b010);
    a[0] = 3'b000;
    step(); step();
    chk("single_idle_g", g[0], 3'b000);
    chk("single_idle_busy", {2'b0, busy[0]}, 3'b000);

    // Reset mid-grant restores last=3
    a[0] = 3'b010;
    step();
    chk("midrst_g2", g[0], 3'b010);
    a[0] = 3'b110;
    rn[0] = 1'b0;
    step();
    chk("midrst_g", g[0], 3'b000);
    chk("midrst_busy", {2'b0, busy[0]}, 3'b000);
    chk("midrst_pre", {2'b0, pre[0]}, 3'b000);
    rn[0] = 1'b1;
    step();
    chk("midrst_after_g2", g[0], 3'b010);

    // Z follows requests combinationally
    a[0] = 3'b000; #1;
    chk("z_low", {2'b0, z[0]}, 3'b000);
    a[0] = 3'b100; #1;
    chk("z_high", {2'b0, z[0]}, 3'b001);

    // Preemption with HOLD_MAX=4
    rn[1] = 1'b1;
    a[1] = 3'b001;
    step();
    chk("pre4_g1", g[1], 3'b001);
    a[1] = 3'b101;
    step(); chk("pre4_hold", g[1], 3'b001);
    step(); chk("pre4_hold", g[1], 3'b001);
    step(); chk("pre4_hold", g[1], 3'b001);
    chk("pre4_nopre", {2'b0, pre[1]}, 3'b000);
    step();
    chk("pre4_rel_g", g[1], 3'b000);
    chk("pre4_pulse", {2'b0, pre[1]}, 3'b001);
    chk("pre4_rel_busy", {2'b0, busy[1]}, 3'b001);
    step();
    chk("pre4_g3", g[1], 3'b100);
    chk("pre4_pre_low", {2'b0, pre[1]}, 3'b000);
    a[1] = 3'b001;
    step();
    chk("pre4_rel2_g", g[1], 3'b000);
    chk("pre4_rel2_pre", {2'b0, pre[1]}, 3'b000);
    step();
    chk("pre4_g1_back", g[1], 3'b001);

    // HOLD_MAX=1: preempted after every granted cycle under contention
    rn[2] = 1'b1;
    a[2] = 3'b011;
    step(); chk("hm1_g1", g[2], 3'b001);
    step(); chk("hm1_rel_g", g[2], 3'b000);
    chk("hm1_pre", {2'b0, pre[2]}, 3'b001);
    step(); chk("hm1_g2", g[2], 3'b010);
    step(); chk("hm1_rel2_g", g[2], 3'b000);
    chk("hm1_pre2", {2'b0, pre[2]}, 3'b001);
    step(); chk("hm1_g1_again", g[2], 3'b001);

    // HOLD_MAX=0: no preemption ever
    rn[3] = 1'b1;
    a[3] = 3'b011;
    step();
    chk("hm0_g1", g[3], 3'b001);
    for (int i = 0; i < 100; i++) begin
      step();
      chk("hm0_hold", g[3], 3'b001);
      chk("hm0_nopre", {2'b0, pre[3]}, 3'b000);
    end
    chk("hm0_busy", {2'b0, busy[3]}, 3'b001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
